// File: rtl/writeback_arbiter.sv
// ============================================================================
// writeback_arbiter
//
// Purpose:
//   Two-requester round-robin arbiter in front of a register-file write port.
//   One write is accepted per cycle. The accepted write reaches the register
//   file one cycle later on RW/BusW/RegWr. A 32-bit scoreboard (Busy) tracks
//   registers that have been allocated but not yet written back. Register 31
//   is a discard target: writes to it are accepted, never reach the register
//   file, and raise a one-cycle Dropped pulse.
//
// Handshake (applies to both requesters):
//   A transfer happens on a rising Clk edge where ReqnValid and ReqnReady are
//   both high. ReqnReady is combinational from the valids and the current
//   priority, and never depends on ReqnReady. At most one ReqnReady is high
//   in any cycle. Request fields are sampled only on the edge of the
//   transfer, so they may change freely while the requester is not granted.
//
// Ports:
//   Clk                  rising-edge clock
//   resetl               asynchronous active-low reset
//   Req0Valid/Req1Valid  requester n presents a write
//   Req0Reg/Req1Reg      destination register number (5 bits)
//   Req0Data/Req1Data    write data (64 bits)
//   Req0Ready/Req1Ready  requester n is granted this cycle
//   AllocValid/AllocReg  mark AllocReg as pending a write
//   RW/BusW/RegWr        register-file write address, data and enable
//   Busy                 per-register pending-write scoreboard
//   Dropped              one-cycle pulse after an accepted write to r31
// ============================================================================
module writeback_arbiter #(
    parameter int unsigned START_PRIO = 0
) (
    input  logic        Clk,
    input  logic        resetl,
    input  logic        Req0Valid,
    input  logic [4:0]  Req0Reg,
    input  logic [63:0] Req0Data,
    output logic        Req0Ready,
    input  logic        Req1Valid,
    input  logic [4:0]  Req1Reg,
    input  logic [63:0] Req1Data,
    output logic        Req1Ready,
    input  logic        AllocValid,
    input  logic [4:0]  AllocReg,
    output logic [4:0]  RW,
    output logic [63:0] BusW,
    output logic        RegWr,
    output logic [31:0] Busy,
    output logic        Dropped
);

    localparam logic       LP_START_PRIO = (START_PRIO != 0);
    localparam logic [4:0] LP_DISCARD    = 5'd31;

    // Priority holder: 0 -> requester 0 wins a tie, 1 -> requester 1 wins.
    logic        r_prio;
    logic [4:0]  r_rw;
    logic [63:0] r_busw;
    logic        r_regwr;
    logic        r_dropped;
    logic [31:0] r_busy;

    logic        w_grant0;
    logic        w_grant1;
    logic        w_xfer;
    logic [4:0]  w_sel_reg;
    logic [63:0] w_sel_data;
    logic        w_to_discard;
    logic        w_write;
    logic [31:0] w_busy_nxt;

    // A lone valid requester is granted regardless of priority; on a tie the
    // priority holder wins. Grants are suppressed while reset is asserted.
    assign w_grant0 = resetl & Req0Valid & (~Req1Valid | ~r_prio);
    assign w_grant1 = resetl & Req1Valid & (~Req0Valid |  r_prio);
    assign w_xfer   = w_grant0 | w_grant1;

    assign w_sel_reg    = w_grant1 ? Req1Reg  : Req0Reg;
    assign w_sel_data   = w_grant1 ? Req1Data : Req0Data;
    assign w_to_discard = (w_sel_reg == LP_DISCARD);
    assign w_write      = w_xfer & ~w_to_discard;

    // Clear on write-back first, then set on alloc, so an alloc and a
    // write-back to the same register on one edge leave it pending.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_xfer) begin
            w_busy_nxt[w_sel_reg] = 1'b0;
        end
        if (AllocValid && (AllocReg != LP_DISCARD)) begin
            w_busy_nxt[AllocReg] = 1'b1;
        end
        w_busy_nxt[31] = 1'b0;
    end

    always_ff @(posedge Clk or negedge resetl) begin
        if (!resetl) begin
            r_prio    <= LP_START_PRIO;
            r_rw      <= 5'd0;
            r_busw    <= 64'd0;
            r_regwr   <= 1'b0;
            r_dropped <= 1'b0;
            r_busy    <= 32'd0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_regwr   <= w_write;
            r_dropped <= w_xfer & w_to_discard;
            // RW/BusW only move on a real write, so they hold while RegWr=0
            // (including the cycle after a discarded r31 write).
            if (w_write) begin
                r_rw   <= w_sel_reg;
                r_busw <= w_sel_data;
            end
            // Round-robin: the non-granted requester takes priority.
            if (w_xfer) begin
                r_prio <= w_grant0;
            end
        end
    end

    assign Req0Ready = w_grant0;
    assign Req1Ready = w_grant1;
    assign RW        = r_rw;
    assign BusW      = r_busw;
    assign RegWr     = r_regwr;
    assign Dropped   = r_dropped;
    assign Busy      = r_busy;

endmodule

// File: tb/tb_writeback_arbiter.sv
// ============================================================================
// tb_writeback_arbiter
//
// Bench for writeback_arbiter. A behavioural model keeps the priority holder
// as an integer, the scoreboard as a bit array and the expected register-file
// writes in a queue. A small register file is attached to RW/BusW/RegWr so
// that end-to-end contents can be read back.
// ============================================================================
module tb_writeback_arbiter;

    localparam int START_PRIO = 0;
    localparam int W          = 69;   // {reg[4:0], data[63:0]}

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic        Clk = 1'b0;
    logic        resetl;
    logic        Req0Valid, Req1Valid;
    logic [4:0]  Req0Reg, Req1Reg;
    logic [63:0] Req0Data, Req1Data;
    logic        Req0Ready, Req1Ready;
    logic        AllocValid;
    logic [4:0]  AllocReg;
    logic [4:0]  RW;
    logic [63:0] BusW;
    logic        RegWr;
    logic [31:0] Busy;
    logic        Dropped;

    always #5 Clk = ~Clk;

    writeback_arbiter #(.START_PRIO(START_PRIO)) dut (
        .Clk        (Clk),
        .resetl     (resetl),
        .Req0Valid  (Req0Valid),
        .Req0Reg    (Req0Reg),
        .Req0Data   (Req0Data),
        .Req0Ready  (Req0Ready),
        .Req1Valid  (Req1Valid),
        .Req1Reg    (Req1Reg),
        .Req1Data   (Req1Data),
        .Req1Ready  (Req1Ready),
        .AllocValid (AllocValid),
        .AllocReg   (AllocReg),
        .RW         (RW),
        .BusW       (BusW),
        .RegWr      (RegWr),
        .Busy       (Busy),
        .Dropped    (Dropped)
    );

    // Register file driven by the DUT write port.
    logic [63:0] tb_rf [32];
    logic        rf_clear = 1'b0;

    initial begin
        for (int i = 0; i < 32; i++) tb_rf[i] = 64'd0;
    end

    always @(posedge Clk) begin
        if (rf_clear) begin
            for (int i = 0; i < 31; i++) tb_rf[i] <= 64'd0;
        end else if (RegWr) begin
            tb_rf[RW] <= BusW;
        end
    end

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_prio;
    bit          m_busy [32];
    logic [4:0]  exp_rw;
    logic [63:0] exp_busw;
    logic        exp_regwr;
    logic        exp_dropped;
    logic [W-1:0] exp_q[$];

    task automatic model_reset();
        m_prio      = START_PRIO;
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        exp_rw      = 5'd0;
        exp_busw    = 64'd0;
        exp_regwr   = 1'b0;
        exp_dropped = 1'b0;
    endtask

    // Which requester wins this cycle: -1 none, 0 or 1.
    function automatic int model_grant();
        if (!resetl) return -1;
        if (Req0Valid && Req1Valid) return m_prio;
        if (Req0Valid) return 0;
        if (Req1Valid) return 1;
        return -1;
    endfunction

    function automatic logic [31:0] model_busy_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    // Advance the model by one rising edge using the current inputs.
    task automatic model_edge();
        int          g;
        int          r;
        logic [63:0] d;
        if (!resetl) begin
            model_reset();
            return;
        end
        g = model_grant();
        r = 0;
        d = 64'd0;
        if (g >= 0) begin
            r = (g == 1) ? int'(Req1Reg) : int'(Req0Reg);
            d = (g == 1) ? Req1Data : Req0Data;
            m_busy[r] = 1'b0;
        end
        if (AllocValid && AllocReg != 5'd31) m_busy[AllocReg] = 1'b1;
        m_busy[31]  = 1'b0;
        exp_regwr   = (g >= 0) && (r != 31);
        exp_dropped = (g >= 0) && (r == 31);
        if (exp_regwr) begin
            exp_rw   = 5'(r);
            exp_busw = d;
            exp_q.push_back({5'(r), d});
        end
        if (g >= 0) m_prio = 1 - g;
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic tick();
        model_edge();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        Req0Valid  = 1'b0;
        Req1Valid  = 1'b0;
        AllocValid = 1'b0;
    endtask

    task automatic drive_req(input int who, input logic [4:0] r, input logic [63:0] d);
        if (who == 0) begin
            Req0Valid = 1'b1; Req0Reg = r; Req0Data = d;
        end else begin
            Req1Valid = 1'b1; Req1Reg = r; Req1Data = d;
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        resetl = 1'b0;
        idle_inputs();
        drive_req(0, 5'd3, 64'hDEAD);
        drive_req(1, 5'd4, 64'hBEEF);
        AllocValid = 1'b1; AllocReg = 5'd2;
        model_reset();
        #3;
        n_checks++; if (Req0Ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready0: got %b expected 0", Req0Ready); end
        n_checks++; if (Req1Ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready1: got %b expected 0", Req1Ready); end
        tick();
        n_checks++; if (RegWr !== 1'b0) begin n_fail++; $display("FAIL reset_regwr: got %b expected 0", RegWr); end
        n_checks++; if (Dropped !== 1'b0) begin n_fail++; $display("FAIL reset_dropped: got %b expected 0", Dropped); end
        n_checks++; if (RW !== 5'd0) begin n_fail++; $display("FAIL reset_rw: got %0d expected 0", RW); end
        n_checks++; if (BusW !== 64'd0) begin n_fail++; $display("FAIL reset_busw: got %0h expected 0", BusW); end
        n_checks++; if (Busy !== 32'd0) begin n_fail++; $display("FAIL reset_busy: got %h expected 0", Busy); end
        idle_inputs();
        resetl = 1'b1;
    endtask

    task automatic test_single();
        // Lone requester 0 with priority at 0.
        drive_req(0, 5'd5, 64'hA5);
        #1;
        n_checks++; if (Req0Ready !== 1'b1) begin n_fail++; $display("FAIL single_ready0: got %b expected 1", Req0Ready); end
        n_checks++; if (Req1Ready !== 1'b0) begin n_fail++; $display("FAIL single_ready1: got %b expected 0", Req1Ready); end
        tick();
        idle_inputs();
        n_checks++; if (RW !== 5'd5) begin n_fail++; $display("FAIL single_rw: got %0d expected 5", RW); end
        n_checks++; if (BusW !== 64'hA5) begin n_fail++; $display("FAIL single_busw: got %0h expected a5", BusW); end
        n_checks++; if (RegWr !== 1'b1) begin n_fail++; $display("FAIL single_regwr: got %b expected 1", RegWr); end
        tick();
        n_checks++; if (RegWr !== 1'b0) begin n_fail++; $display("FAIL single_regwr_pulse: got %b expected 0", RegWr); end
        n_checks++; if (RW !== 5'd5 || BusW !== 64'hA5) begin n_fail++; $display("FAIL single_hold: got %0d/%0h expected 5/a5", RW, BusW); end
        // Priority now with requester 1; a lone requester 0 must still win.
        drive_req(0, 5'd3, 64'h33);
        #1;
        n_checks++; if (Req0Ready !== 1'b1) begin n_fail++; $display("FAIL single_nonprio0: got %b expected 1", Req0Ready); end
        tick();
        idle_inputs();
        n_checks++; if (RW !== 5'd3) begin n_fail++; $display("FAIL single_rw3: got %0d expected 3", RW); end
        drive_req(1, 5'd4, 64'h44);
        #1;
        n_checks++; if (Req1Ready !== 1'b1) begin n_fail++; $display("FAIL single_ready1b: got %b expected 1", Req1Ready); end
        tick();
        idle_inputs();
        n_checks++; if (RW !== 5'd4 || BusW !== 64'h44) begin n_fail++; $display("FAIL single_rw4: got %0d/%0h expected 4/44", RW, BusW); end
        tick();
    endtask

    task automatic test_back_to_back();
        // Priority is with requester 0 here; grants must go 0,1,0,1.
        drive_req(0, 5'd1, 64'h11);
        drive_req(1, 5'd2, 64'h22);
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (Req0Ready !== (i % 2 == 0) || Req1Ready !== (i % 2 == 1)) begin
                n_fail++;
                $display("FAIL b2b_grant%0d: got %b%b expected %b%b", i, Req0Ready, Req1Ready, (i % 2 == 0), (i % 2 == 1));
            end
            tick();
            n_checks++;
            if (RegWr !== 1'b1 || RW !== ((i % 2 == 0) ? 5'd1 : 5'd2)) begin
                n_fail++;
                $display("FAIL b2b_rw%0d: got regwr=%b rw=%0d expected regwr=1 rw=%0d", i, RegWr, RW, (i % 2 == 0) ? 1 : 2);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_drop31();
        drive_req(1, 5'd31, 64'h12345678);
        #1;
        n_checks++; if (Req1Ready !== 1'b1) begin n_fail++; $display("FAIL drop_ready1: got %b expected 1", Req1Ready); end
        tick();
        idle_inputs();
        n_checks++; if (RegWr !== 1'b0) begin n_fail++; $display("FAIL drop_regwr: got %b expected 0", RegWr); end
        n_checks++; if (Dropped !== 1'b1) begin n_fail++; $display("FAIL drop_pulse: got %b expected 1", Dropped); end
        n_checks++; if (RW !== 5'd2 || BusW !== 64'h22) begin n_fail++; $display("FAIL drop_hold: got %0d/%0h expected 2/22", RW, BusW); end
        tick();
        n_checks++; if (Dropped !== 1'b0) begin n_fail++; $display("FAIL drop_pulse_end: got %b expected 0", Dropped); end
        n_checks++; if (tb_rf[31] !== 64'd0) begin n_fail++; $display("FAIL drop_rf31: got %0h expected 0", tb_rf[31]); end
    endtask

    task automatic test_busy();
        AllocValid = 1'b1; AllocReg = 5'd7;
        tick();
        AllocValid = 1'b0;
        n_checks++; if (Busy[7] !== 1'b1) begin n_fail++; $display("FAIL busy_set: got %b expected 1", Busy[7]); end
        tick();
        n_checks++; if (Busy[7] !== 1'b1) begin n_fail++; $display("FAIL busy_hold: got %b expected 1", Busy[7]); end
        drive_req(0, 5'd7, 64'h77);
        tick();
        idle_inputs();
        n_checks++; if (Busy[7] !== 1'b0) begin n_fail++; $display("FAIL busy_clear: got %b expected 0", Busy[7]); end
        // Set wins over a same-edge clear.
        AllocValid = 1'b1; AllocReg = 5'd7;
        tick();
        drive_req(1, 5'd7, 64'h770);
        tick();
        idle_inputs();
        n_checks++; if (Busy[7] !== 1'b1) begin n_fail++; $display("FAIL busy_set_wins: got %b expected 1", Busy[7]); end
        // Alloc of r31 is ignored; alloc and clear on different registers.
        AllocValid = 1'b1; AllocReg = 5'd31;
        tick();
        n_checks++; if (Busy[31] !== 1'b0) begin n_fail++; $display("FAIL busy_r31: got %b expected 0", Busy[31]); end
        AllocReg = 5'd12;
        drive_req(0, 5'd7, 64'h7);
        tick();
        idle_inputs();
        n_checks++; if (Busy !== model_busy_vec()) begin n_fail++; $display("FAIL busy_vec: got %h expected %h", Busy, model_busy_vec()); end
    endtask

    task automatic test_random();
        logic [W-1:0] e;
        int           g;
        exp_q.delete();
        for (int i = 0; i <= 400; i++) begin
            if (i == 400) begin
                idle_inputs();
            end else begin
                Req0Valid  = ($urandom_range(0, 3) != 0);
                Req1Valid  = ($urandom_range(0, 3) != 0);
                Req0Reg    = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
                Req1Reg    = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
                Req0Data   = {$urandom, $urandom};
                Req1Data   = {$urandom, $urandom};
                AllocValid = ($urandom_range(0, 1) == 1);
                AllocReg   = 5'($urandom_range(0, 31));
            end
            #1;
            g = model_grant();
            n_checks++;
            if (Req0Ready !== (g == 0) || Req1Ready !== (g == 1)) begin
                n_fail++;
                $display("FAIL rand_grant c%0d: got %b%b expected %b%b", i, Req0Ready, Req1Ready, (g == 0), (g == 1));
            end
            tick();
            n_checks++;
            if (RegWr !== exp_regwr || Dropped !== exp_dropped) begin
                n_fail++;
                $display("FAIL rand_ctl c%0d: got regwr=%b dropped=%b expected %b %b", i, RegWr, Dropped, exp_regwr, exp_dropped);
            end
            n_checks++;
            if (Busy !== model_busy_vec()) begin
                n_fail++;
                $display("FAIL rand_busy c%0d: got %h expected %h", i, Busy, model_busy_vec());
            end
            n_checks++;
            if (RW !== exp_rw || BusW !== exp_busw) begin
                n_fail++;
                $display("FAIL rand_hold c%0d: got %0d/%0h expected %0d/%0h", i, RW, BusW, exp_rw, exp_busw);
            end
            if (RegWr === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_sb c%0d: got write %0d/%0h expected none", i, RW, BusW);
                end else begin
                    e = exp_q.pop_front();
                    if ({RW, BusW} !== e) begin
                        n_fail++;
                        $display("FAIL rand_sb c%0d: got %0d/%0h expected %0d/%0h", i, RW, BusW, e[68:64], e[63:0]);
                    end
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_sb_left: got %0d writes outstanding expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        // Put priority on requester 1 and leave a write in flight.
        AllocValid = 1'b1; AllocReg = 5'd9;
        drive_req(0, 5'd8, 64'h88);
        tick();
        AllocValid = 1'b0;
        Req0Valid  = 1'b0;
        drive_req(0, 5'd10, 64'h1010);
        drive_req(1, 5'd11, 64'h1111);
        #1;
        n_checks++; if (Req1Ready !== 1'b1 || RegWr !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got ready1=%b regwr=%b expected 1 1", Req1Ready, RegWr); end
        resetl = 1'b0;
        model_reset();
        #1;
        n_checks++; if (RegWr !== 1'b0) begin n_fail++; $display("FAIL mid_regwr: got %b expected 0", RegWr); end
        n_checks++; if (Busy !== 32'd0) begin n_fail++; $display("FAIL mid_busy: got %h expected 0", Busy); end
        n_checks++; if (Req0Ready !== 1'b0 || Req1Ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got %b%b expected 00", Req0Ready, Req1Ready); end
        tick();
        n_checks++; if (RegWr !== 1'b0 || RW !== 5'd0) begin n_fail++; $display("FAIL mid_held: got regwr=%b rw=%0d expected 0 0", RegWr, RW); end
        resetl = 1'b1;
        #1;
        n_checks++; if (Req0Ready !== 1'b1 || Req1Ready !== 1'b0) begin n_fail++; $display("FAIL mid_prio: got %b%b expected 10", Req0Ready, Req1Ready); end
        tick();
        idle_inputs();
        n_checks++; if (RegWr !== 1'b1 || RW !== 5'd10) begin n_fail++; $display("FAIL mid_first: got regwr=%b rw=%0d expected 1 10", RegWr, RW); end
        tick();
    endtask

    task automatic test_regfile();
        rf_clear = 1'b1;
        tick();
        rf_clear = 1'b0;
        for (int r = 1; r <= 30; r++) begin
            drive_req(int'($urandom_range(0, 1)), 5'(r), 64'(r));
            tick();
            idle_inputs();
            if ($urandom_range(0, 2) == 0) tick();
        end
        tick();
        tick();
        for (int r = 0; r < 32; r++) begin
            n_checks++;
            if (tb_rf[r] !== ((r == 31) ? 64'd0 : 64'(r))) begin
                n_fail++;
                $display("FAIL rf_r%0d: got %0h expected %0h", r, tb_rf[r], (r == 31) ? 0 : r);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------
    initial begin
        Req0Reg  = 5'd0; Req1Reg  = 5'd0;
        Req0Data = 64'd0; Req1Data = 64'd0;
        AllocReg = 5'd0;
        test_reset();
        test_single();
        test_back_to_back();
        test_drop31();
        test_busy();
        test_random();
        test_reset_mid();
        test_regfile();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
